// File: rtl/ram_ctrl_pkg.sv
// Shared types and default sizes for the RAM port arbiter and its round-robin helper.
package ram_ctrl_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic {
    INIT,
    SERVE
  } state_t;

  typedef enum logic {
    REQ_A,
    REQ_B
  } req_id_t;

endpackage

// File: rtl/ram_port_arbiter_arb.sv
// Two-way round-robin arbiter; on a tie the requester that did not win last time is granted.
module rr_arb2
  import ram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  req_id_t last_gnt;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = (last_gnt == REQ_B) ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  // history only moves on an actual grant so idle cycles keep fairness
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_gnt <= REQ_B;
    else if (gnt[0]) last_gnt <= REQ_A;
    else if (gnt[1]) last_gnt <= REQ_B;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Owns the single RAM port: zero-fills after reset/clear, then shares it between A and B.
// state | meaning
// INIT  | writing INIT_VAL to every address, no grants
// SERVE | round-robin one access per cycle, rvalid one cycle after a read grant
module ram_port_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              init_done,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  state_t            state;
  logic [ADDR_W-1:0] fill_cnt;
  logic [1:0]        gnt;
  logic              arb_en;

  // a clear in SERVE blocks grants in the same cycle it is seen
  assign arb_en = (state == SERVE) && !clr_req;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({b_req, a_req}),
    .en  (arb_en),
    .gnt (gnt)
  );

  assign a_gnt = gnt[0];
  assign b_gnt = gnt[1];

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (state == INIT) begin
      ram_we   = 1'b1;
      ram_addr = fill_cnt;
      ram_din  = INIT_VAL;
    end else if (gnt[0]) begin
      ram_we   = a_we;
      ram_addr = a_addr;
      ram_din  = a_wdata;
    end else if (gnt[1]) begin
      ram_we   = b_we;
      ram_addr = b_addr;
      ram_din  = b_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      fill_cnt  <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          fill_cnt <= fill_cnt + ADDR_W'(1);
          if (fill_cnt == {ADDR_W{1'b1}}) begin
            state     <= SERVE;
            init_done <= 1'b1;
          end
        end
        SERVE: begin
          if (clr_req) begin
            state     <= INIT;
            fill_cnt  <= '0;
            init_done <= 1'b0;
          end
        end
        default: begin
          state     <= INIT;
          fill_cnt  <= '0;
          init_done <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      a_rvalid <= a_gnt & ~a_we;
      b_rvalid <= b_gnt & ~b_we;
    end
  end

  // the RAM output register already holds the read word during the valid cycle
  assign a_rdata = ram_dout;
  assign b_rdata = ram_dout;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed plus randomized bench for ram_port_arbiter against a behavioural port/memory model.
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr_req;
  logic       init_done;
  logic       a_req, a_we, a_gnt, a_rvalid;
  logic [3:0] a_addr;
  logic [7:0] a_wdata, a_rdata;
  logic       b_req, b_we, b_gnt, b_rvalid;
  logic [3:0] b_addr;
  logic [7:0] b_wdata, b_rdata;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout = 8'h00;
  logic [7:0] ram_mem [16];

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  bit       m_fill;
  int       m_idx;
  bit       m_last_b;
  bit       m_pa, m_pb;
  bit [7:0] m_da, m_db;
  bit [7:0] m_mem [16];
  int       m_win;

  ram_port_arbiter dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .init_done(init_done),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // single-port RAM with registered read that holds on writes
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    else        ram_dout <= ram_mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic m_reset();
    m_fill = 1; m_idx = 0; m_last_b = 1; m_pa = 0; m_pb = 0; m_win = 0;
  endtask

  task automatic step(input logic ar, input logic aw, input logic [3:0] aa, input logic [7:0] ad,
                      input logic br, input logic bw, input logic [3:0] ba, input logic [7:0] bd,
                      input logic clr);
    bit       e_we, e_done;
    bit [3:0] e_addr;
    bit [7:0] e_din;
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    clr_req = clr;
    e_we = 0; e_addr = 0; e_din = 0; m_win = 0;
    if (m_fill) begin
      e_done = 0; e_we = 1; e_addr = 4'(m_idx); e_din = 8'h00;
    end else begin
      e_done = 1;
      if (!clr) begin
        if (ar && br) m_win = m_last_b ? 1 : 2;
        else if (ar)  m_win = 1;
        else if (br)  m_win = 2;
      end
      if (m_win == 1) begin e_we = aw; e_addr = aa; e_din = ad; end
      if (m_win == 2) begin e_we = bw; e_addr = ba; e_din = bd; end
    end
    @(negedge clk);
    chk("init_done", init_done, e_done);
    chk("a_gnt", a_gnt, m_win == 1);
    chk("b_gnt", b_gnt, m_win == 2);
    chk("ram_we", ram_we, e_we);
    chk("ram_addr", ram_addr, e_addr);
    chk("ram_din", ram_din, e_din);
    chk("a_rvalid", a_rvalid, m_pa);
    chk("b_rvalid", b_rvalid, m_pb);
    if (m_pa) chk("a_rdata", a_rdata, m_da);
    if (m_pb) chk("b_rdata", b_rdata, m_db);
    @(posedge clk);
    m_pa = (m_win == 1) && !aw; m_da = m_mem[aa];
    m_pb = (m_win == 2) && !bw; m_db = m_mem[ba];
    if (m_fill) begin
      m_mem[m_idx] = 8'h00;
      if (m_idx == 15) m_fill = 0;
      m_idx = (m_idx + 1) % 16;
    end else if (clr) begin
      m_fill = 1; m_idx = 0;
    end else if (m_win == 1) begin
      if (aw) m_mem[aa] = ad;
      m_last_b = 0;
    end else if (m_win == 2) begin
      if (bw) m_mem[ba] = bd;
      m_last_b = 1;
    end
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rst_check();
    chk("rst init_done", init_done, 0);
    chk("rst a_rvalid", a_rvalid, 0);
    chk("rst b_rvalid", b_rvalid, 0);
    chk("rst a_gnt", a_gnt, 0);
    chk("rst b_gnt", b_gnt, 0);
    chk("rst ram_we", ram_we, 1);
    chk("rst ram_addr", ram_addr, 0);
  endtask

  initial begin
    logic       ar, aw, br, bw, clr, a_wait, b_wait;
    logic [3:0] aa, ba;
    logic [7:0] ad, bd;
    rst = 1; clr_req = 0;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    m_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_check();
    rst = 0;

    // fill after reset, then first SERVE cycle
    idle(17);

    // A write then read of the same address
    step(1, 1, 4'd3, 8'h5A, 0, 0, 0, 0, 0);
    step(1, 0, 4'd3, 8'h00, 0, 0, 0, 0, 0);
    idle(1);

    // preload, then contending reads alternate A,B,A,B
    step(1, 1, 4'd1, 8'h11, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 4'd2, 8'h22, 0);
    repeat (4) step(1, 0, 4'd1, 8'h00, 1, 0, 4'd2, 8'h00, 0);
    idle(1);

    // clear while B waits; B only served after refill, reading zero
    step(1, 1, 4'd15, 8'hFF, 0, 0, 0, 0, 0);
    repeat (17) step(0, 0, 0, 0, 1, 0, 4'd15, 8'h00, (m_fill == 0));
    step(0, 0, 0, 0, 1, 0, 4'd15, 8'h00, 0);
    idle(1);

    // read grant followed by clear still delivers the read
    step(1, 1, 4'd5, 8'h77, 0, 0, 0, 0, 0);
    step(1, 0, 4'd5, 8'h00, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(7);

    // reset in the middle of the fill at fill_cnt = 7
    chk("midfill addr", ram_addr, 7);
    rst = 1; #2;
    m_reset();
    rst_check();
    @(posedge clk); #1;
    rst = 0;
    idle(17);

    a_wait = 0; b_wait = 0;
    ar = 0; aw = 0; aa = 0; ad = 0; br = 0; bw = 0; ba = 0; bd = 0;
    repeat (400) begin
      if (!a_wait) begin
        ar = ($urandom_range(0, 3) != 0); aw = 1'($urandom_range(0, 1));
        aa = 4'($urandom_range(0, 15));   ad = 8'($urandom);
      end
      if (!b_wait) begin
        br = ($urandom_range(0, 3) != 0); bw = 1'($urandom_range(0, 1));
        ba = 4'($urandom_range(0, 15));   bd = 8'($urandom);
      end
      clr = ($urandom_range(0, 39) == 0);
      step(ar, aw, aa, ad, br, bw, ba, bd, clr);
      a_wait = ar && (m_win != 1);
      b_wait = br && (m_win != 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Controller that owns the single write/read port of the 16x8 single-port synchronous RAM and shares it between two requesters, A and B.
- After reset, and on an explicit clear request, it first zero-fills every location.
- Once filled, it round-robin arbitrates one access per cycle and returns read data with a valid pulse.
- Sits between the RAM and two client blocks in the same clock domain.

Parameters:
- DATA_W, 8, RAM word width.
- ADDR_W, 4, RAM address width; depth = 2**ADDR_W.
- INIT_VAL, 0, word written to every location during fill.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr_req  in  1  one-cycle request to re-run the fill sequence.
- init_done  out  1  high while in SERVE state.
- a_req  in  1  requester A access request.
- a_we  in  1  A: 1=write, 0=read.
- a_addr  in  ADDR_W  A address.
- a_wdata  in  DATA_W  A write data.
- a_gnt  out  1  combinational accept; the access happens on the edge ending this cycle.
- a_rvalid  out  1  registered; A read data valid.
- a_rdata  out  DATA_W  A read data; meaningful only when a_rvalid=1.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for requester B.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_din  out  DATA_W  RAM write data.
- ram_dout  in  DATA_W  RAM registered read data; updates the edge after a read address is presented, holds on write cycles.

Behaviour:
- Reset values (rst=1): state=INIT, fill_cnt=0, last_gnt=B (so A wins the first tie), init_done=0, a_rvalid=b_rvalid=0.
- INIT state:
  - ram_we=1, ram_addr=fill_cnt, ram_din=INIT_VAL; a_gnt=b_gnt=0.
  - fill_cnt increments each cycle.
  - On the cycle where fill_cnt=2**ADDR_W-1: write that location, fill_cnt wraps to 0, next state=SERVE.
  - init_done rises on the edge after the 16th write: the 16th rising edge after rst deasserts.
  - clr_req is ignored in INIT.
- SERVE state, grant:
  - Neither req: no grant; ram_we=0, ram_addr=0, ram_din=0. This is a harmless read of addr 0 and does not raise rvalid.
  - Exactly one req: that requester is granted.
  - Both req: grant the requester that is not last_gnt.
  - last_gnt updates only on a grant.
- SERVE state, granted access:
  - ram_we, ram_addr and ram_din are driven combinationally from the granted requester's we/addr/wdata.
  - A granted read (we=0) sets that requester's rvalid=1 for exactly the next cycle. rdata = ram_dout, routed combinationally; latency is 1 cycle from the grant cycle.
  - A granted write produces no rvalid.
- A requester not granted must hold req/we/addr/wdata stable until granted.
- clr_req=1 in SERVE:
  - Highest priority that cycle: no grants, ram_we=0.
  - Next state=INIT, fill_cnt=0, init_done falls on that edge.
  - An rvalid already registered from the previous cycle's grant is still delivered.
- Simultaneous events:
  - Write then read to the same address in consecutive cycles returns the new data.
  - Back-to-back reads from alternating requesters give rvalid on consecutive cycles with correct per-requester data.
- rst asserted mid-fill or mid-read: immediate return to reset values; the fill restarts from address 0 and any pending rvalid is dropped.
- Widths: fill_cnt is ADDR_W bits and wraps naturally; no arithmetic on data.

Decomposition:
- Package ram_ctrl_pkg:
  - state enum {INIT, SERVE};
  - requester id enum {REQ_A, REQ_B};
  - default DATA_W/ADDR_W constants.
- Sub-module rr_arb2: 2-way round-robin arbiter holding last_gnt, with inputs req[1:0], en, and output gnt[1:0].
- The top level holds the FSM, fill counter, port mux and rvalid registers.

Test Plan:
- Reset release, no requests:
  - ram_we=1 for exactly 16 cycles with ram_addr 0..15 and ram_din=0x00;
  - init_done=1 after edge 16; no gnt during fill.
- After init, A writes 0x5A to addr 3, then A reads addr 3:
  - a_gnt both cycles;
  - a_rvalid=1 one cycle after the read grant with a_rdata=0x5A; b_rvalid stays 0.
- A and B both request reads (addrs 1 and 2, preloaded 0x11/0x22) for 4 cycles:
  - grants A,B,A,B;
  - rvalids alternate a/b with data 0x11/0x22.
- Write 0xFF to addr 15, then pulse clr_req while B requests:
  - no grant that cycle;
  - init_done falls and the 16-cycle fill repeats;
  - a later read of addr 15 returns 0x00; B is granted only after init_done.
- Assert rst during fill at fill_cnt=7:
  - all outputs return to reset values;
  - the fill restarts at addr 0 and completes 16 writes.
- Read grant followed by clr_req in the next cycle: the rvalid for the read still appears with the correct data.
